// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC moving-average block.
package adc_pkg;

  localparam int ADC_W = 12;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } adc_state_e;

endpackage

// File: rtl/adc_sample_ring.sv
// Sample ring buffer with wrapping write pointer; the entry about to be
// overwritten is presented combinationally so the caller can evict it.
module adc_sample_ring
  import adc_pkg::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [ADC_W-1:0]      wr_data_i,
  output logic [ADC_W-1:0]      evict_o,
  output logic [LOG2_DEPTH-1:0] wr_ptr_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [ADC_W-1:0]      mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q;
  logic [LOG2_DEPTH-1:0] ptr_d;

  assign evict_o  = mem_q[ptr_q];
  assign wr_ptr_o = ptr_q;

  // Storage write; no reset, stale entries are masked while filling.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[ptr_q] <= wr_data_i;
    end
  end

  // Next write pointer: power-of-two depth makes the wrap implicit.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = {LOG2_DEPTH{1'b0}};
    end else if (wr_en_i) begin
      ptr_d = ptr_q + LOG2_DEPTH'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Write pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= {LOG2_DEPTH{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adc_moving_avg.sv
// Windowed moving average of ADC samples with a two-stage update pipeline.
// Optional hysteresis alarm enabled by defining ADC_AVG_ALARM_EN.
module adc_moving_avg
  import adc_pkg::*;
#(
  parameter int LOG2_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] din,
  input  logic             din_valid,
  input  logic             clear,
  input  logic [ADC_W-1:0] thr_hi,
  input  logic [ADC_W-1:0] thr_lo,
  output logic [ADC_W-1:0] avg,
  output logic             avg_valid,
  output logic             full,
  output logic             alarm
);

  localparam int SUM_W = ADC_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = {LOG2_DEPTH{1'b1}};

  adc_state_e            state_q, state_d;
  logic [LOG2_DEPTH-1:0] count_q, count_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADC_W-1:0]      avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  full_q;
  logic                  alarm_q, alarm_d;

  logic                  accept_s;
  logic                  stage2_fire_s;
  logic [ADC_W-1:0]      evict_s;
  logic [ADC_W-1:0]      old_s;
  logic [LOG2_DEPTH-1:0] wr_ptr_s;

  assign accept_s      = din_valid & ~clear;
  assign stage2_fire_s = s1_valid_q & ~clear;

  adc_sample_ring #(
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .wr_en_i   (accept_s),
    .wr_data_i (din),
    .evict_o   (evict_s),
    .wr_ptr_o  (wr_ptr_s)
  );

  logic unused_ptr_s;
  assign unused_ptr_s = ^wr_ptr_s;

  // FSM, stage-1 running sum and stage-2 average update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    s1_valid_d  = 1'b0;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    old_s       = (state_q == RUN) ? evict_s : {ADC_W{1'b0}};
    if (clear) begin
      state_d = FILL;
      count_d = {LOG2_DEPTH{1'b0}};
      sum_d   = {SUM_W{1'b0}};
    end else begin
      if (stage2_fire_s) begin
        avg_d       = sum_q[SUM_W-1:LOG2_DEPTH];
        avg_valid_d = 1'b1;
      end else begin
        avg_d = avg_q;
      end
      if (accept_s) begin
        // Intermediate may wrap but the final sum is always in range.
        sum_d = sum_q + SUM_W'(din) - SUM_W'(old_s);
        case (state_q)
          FILL: begin
            count_d = count_q + LOG2_DEPTH'(1);
            if (count_q == LAST_IDX) begin
              state_d    = RUN;
              s1_valid_d = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
          RUN: begin
            s1_valid_d = 1'b1;
          end
          default: begin
            state_d = FILL;
          end
        endcase
      end else begin
        sum_d = sum_q;
      end
    end
  end

`ifdef ADC_AVG_ALARM_EN
  // Hysteresis alarm evaluated against the average being published.
  always_comb begin
    alarm_d = alarm_q;
    if (stage2_fire_s) begin
      if (avg_d > thr_hi) begin
        alarm_d = 1'b1;
      end else if (avg_d < thr_lo) begin
        alarm_d = 1'b0;
      end else begin
        alarm_d = alarm_q;
      end
    end else begin
      alarm_d = alarm_q;
    end
  end
`else
  assign alarm_d = 1'b0;
  logic unused_thr_s;
  assign unused_thr_s = ^{thr_hi, thr_lo};
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= {LOG2_DEPTH{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      s1_valid_q  <= 1'b0;
      avg_q       <= {ADC_W{1'b0}};
      avg_valid_q <= 1'b0;
      full_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      s1_valid_q  <= s1_valid_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      full_q      <= (state_d == RUN);
      alarm_q     <= alarm_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;
  assign full      = full_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed self-checking bench for adc_moving_avg (LOG2_DEPTH = 3).
module tb_adc_moving_avg;

  logic        clk;
  logic        reset;
  logic [11:0] din;
  logic        din_valid;
  logic        clear;
  logic [11:0] thr_hi;
  logic [11:0] thr_lo;
  logic [11:0] avg;
  logic        avg_valid;
  logic        full;
  logic        alarm;

  int errors;
  int checks;

`ifdef ADC_AVG_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  adc_moving_avg #(.LOG2_DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .avg       (avg),
    .avg_valid (avg_valid),
    .full      (full),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Eight back-to-back strobes of one value, then one idle cycle so the
  // last sample's average is visible.
  task automatic fill8(input logic [11:0] v);
    din       = v;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    din_valid = 1'b0;
    tick();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    din       = 12'h000;
    din_valid = 1'b0;
    clear     = 1'b0;
    thr_hi    = 12'hFFF;
    thr_lo    = 12'h000;
    tick();
    tick();
    check_eq("rst_avg", 32'(avg), 32'h000);
    check_eq("rst_avg_valid", 32'(avg_valid), 32'h0);
    check_eq("rst_full", 32'(full), 32'h0);
    check_eq("rst_alarm", 32'(alarm), 32'h0);
    reset = 1'b0;
    tick();

    // Fill with 0x800: full only after the 8th, pulse two cycles later.
    din       = 12'h800;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("fill_full%0d", i), 32'(full), (i == 7) ? 32'h1 : 32'h0);
      check_eq($sformatf("fill_noval%0d", i), 32'(avg_valid), 32'h0);
    end
    din_valid = 1'b0;
    tick();
    check_eq("fill_avg_valid", 32'(avg_valid), 32'h1);
    check_eq("fill_avg", 32'(avg), 32'h800);
    tick();
    check_eq("fill_single_pulse", 32'(avg_valid), 32'h0);
    check_eq("fill_avg_hold", 32'(avg), 32'h800);

    // Zero window, then ramp with 0xFFF: averages 0x200*k - 1.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_full", 32'(full), 32'h0);
    check_eq("clr_avg_hold", 32'(avg), 32'h800);
    din       = 12'h000;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    din = 12'hFFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("ramp_valid%0d", i), 32'(avg_valid), 32'h1);
      check_eq($sformatf("ramp_avg%0d", i), 32'(avg), (i == 0) ? 32'h000 : 32'(i * 32'h200 - 32'h1));
    end
    din_valid = 1'b0;
    tick();
    check_eq("ramp_valid_last", 32'(avg_valid), 32'h1);
    check_eq("ramp_avg_last", 32'(avg), 32'hFFF);

    // Clear after 5 samples with a colliding strobe: sample is dropped.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) strobe(12'h100);
    clear     = 1'b1;
    din       = 12'hFFF;
    din_valid = 1'b1;
    tick();
    clear     = 1'b0;
    din_valid = 1'b0;
    check_eq("drop_full", 32'(full), 32'h0);
    check_eq("drop_avg_hold", 32'(avg), 32'hFFF);
    din       = 12'h200;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("refill_full%0d", i), 32'(full), (i == 7) ? 32'h1 : 32'h0);
      check_eq($sformatf("refill_noval%0d", i), 32'(avg_valid), 32'h0);
    end
    din_valid = 1'b0;
    tick();
    check_eq("refill_valid", 32'(avg_valid), 32'h1);
    check_eq("refill_avg", 32'(avg), 32'h200);

    // Reset between stage 1 and stage 2 kills the pending pulse.
    strobe(12'h400);
    reset = 1'b1;
    #1;
    check_eq("midrst_avg", 32'(avg), 32'h000);
    check_eq("midrst_valid", 32'(avg_valid), 32'h0);
    check_eq("midrst_full", 32'(full), 32'h0);
    check_eq("midrst_alarm", 32'(alarm), 32'h0);
    tick();
    check_eq("midrst_valid_edge", 32'(avg_valid), 32'h0);
    reset = 1'b0;
    tick();
    check_eq("postrst_valid", 32'(avg_valid), 32'h0);
    check_eq("postrst_full", 32'(full), 32'h0);

    // Alarm hysteresis.
    thr_hi = 12'hC00;
    thr_lo = 12'h400;
    fill8(12'hC01);
    check_eq("alm_avg_c01", 32'(avg), 32'hC01);
    check_eq("alm_set", 32'(alarm), 32'(ALARM_ON));
    fill8(12'h800);
    check_eq("alm_avg_800", 32'(avg), 32'h800);
    check_eq("alm_hold", 32'(alarm), 32'(ALARM_ON));
    fill8(12'h3FF);
    check_eq("alm_avg_3ff", 32'(avg), 32'h3FF);
    check_eq("alm_clear", 32'(alarm), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_moving_avg.md
ADC_MOVING_AVG -- requirements
Module: adc_moving_avg

Interface
REQ-001 Parameter LOG2_DEPTH, default 3, meaning: window length = 2**LOG2_DEPTH samples (legal 1..6).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 din  input  12  converted ADC sample from the ADC controller.
REQ-005 din_valid  input  1  one-cycle strobe, din valid this cycle.
REQ-006 clear  input  1  synchronous flush of window, active-high.
REQ-007 thr_hi  input  12  alarm set threshold.
REQ-008 thr_lo  input  12  alarm clear threshold.
REQ-009 avg  output  12  windowed mean of last 2**LOG2_DEPTH samples.
REQ-010 avg_valid  output  1  one-cycle strobe, avg updated this cycle.
REQ-011 full  output  1  high while window holds 2**LOG2_DEPTH samples.
REQ-012 alarm  output  1  threshold alarm with hysteresis.

Function
REQ-013 FSM states FILL and RUN; FILL -> RUN when the 2**LOG2_DEPTH-th sample is accepted; RUN -> FILL only on clear or reset.
REQ-014 Ring buffer of 2**LOG2_DEPTH x 12 bits, write pointer wraps from 2**LOG2_DEPTH-1 to 0.
REQ-015 Accepted sample (din_valid=1, clear=0) written at write pointer; pointer and fill count advance by one, back-to-back strobes accepted every cycle.
REQ-016 Stage 1 (cycle N+1 after strobe in cycle N): sum <= sum + din - old, where old = evicted buffer entry in RUN and 0 in FILL.
REQ-017 sum width 12+LOG2_DEPTH bits, never overflows or goes negative.
REQ-018 Stage 2 (cycle N+2): avg <= sum >> LOG2_DEPTH (truncation), avg_valid pulses one cycle, only if state was RUN after the accepting update.
REQ-019 No avg_valid during FILL; first avg_valid two cycles after the 2**LOG2_DEPTH-th accepted strobe.
REQ-020 avg holds its value between avg_valid pulses.
REQ-021 full = (state == RUN).
REQ-022 clear: state FILL, count 0, pointer 0, sum 0, in-flight stage-2 pulse cancelled; avg and alarm hold their values.
REQ-023 clear and din_valid in the same cycle: clear wins, sample dropped.

Reset
REQ-024 reset asserted at any time: state FILL, pointer 0, count 0, sum 0, avg 0x000, avg_valid 0, full 0, alarm 0; pipeline contents discarded.
REQ-025 Buffer storage needs no reset (FILL masks stale entries per REQ-016).

Configuration
REQ-026 Macro ADC_AVG_ALARM_EN defined: on each avg_valid, alarm sets if new avg > thr_hi, else clears if new avg < thr_lo, else holds; set evaluated first.
REQ-027 Macro ADC_AVG_ALARM_EN undefined: alarm tied 0, thr_hi/thr_lo ignored, no alarm logic synthesized.

Structure
REQ-028 Shared package adc_pkg holds ADC_W=12 and the FSM state enum typedef (FILL, RUN).
REQ-029 Ring buffer and write pointer in sub-module adc_sample_ring (write, read-before-write of evicted entry).

Verification (LOG2_DEPTH=3 unless stated)
REQ-030 8 strobes din=0x800 -> full rises after 8th, single avg_valid 2 cycles later, avg=0x800; none earlier.
REQ-031 Steady 0x000 window then 8 strobes of 0xFFF back-to-back -> avg 0x1FF,0x3FF,...,0xDFF,0xFFF (steps of 0x200 with truncation), sum never wraps.
REQ-032 clear after 5 samples, simultaneous din_valid -> sample dropped, full 0, next avg_valid only after 8 further samples.
REQ-033 reset asserted mid-RUN between stage 1 and stage 2 -> no avg_valid, all outputs at reset values immediately.
REQ-034 ADC_AVG_ALARM_EN defined, thr_hi=0xC00, thr_lo=0x400: avg 0xC01 -> alarm 1; avg 0x800 -> alarm stays 1; avg 0x3FF -> alarm 0.
REQ-035 ADC_AVG_ALARM_EN undefined, same stimulus as REQ-034 -> alarm constantly 0.
